// File: rtl/rice_core_csr_access.sv
// ============================================================================
// rice_core_csr_access : CSR instruction sequencer / CSR bus master
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rice_core_csr_access #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [11:0]        i_address,
    input  logic [XLEN-1:0]    i_operand,
    input  logic               i_rd_zero,
    input  logic               i_rs1_zero,
    output logic               o_done,
    output logic [XLEN-1:0]    o_rdata,
    output logic               o_error,
    output logic               csr_request_valid,
    input  logic               csr_request_ready,
    output logic [11:0]        csr_address,
    output logic               csr_write,
    output logic [XLEN-1:0]    csr_write_data,
    output logic [XLEN/8-1:0]  csr_strobe,
    input  logic               csr_response_valid,
    output logic               csr_response_ready,
    input  logic [XLEN-1:0]    csr_read_data,
    input  logic               csr_error
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_RSP = 3'd2,
        WR_REQ = 3'd3,
        WR_RSP = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       op;
    logic [XLEN-1:0]  operand;
    logic             need_write;

    logic             req_need_read;
    logic             req_need_write;
    logic             req_read_only;
    logic [XLEN-1:0]  new_value;

    // Decode of the incoming request; only consumed in the accepting cycle.
    always_comb begin
        req_need_read  = !(i_op == OP_RW && i_rd_zero);
        req_need_write = (i_op == OP_RW) || !i_rs1_zero;
        req_read_only  = req_need_write && (i_address[11:10] == 2'b11);
    end

    always_comb begin
        new_value = operand;
        case (op)
            OP_RS:   new_value = csr_read_data | operand;
            OP_RC:   new_value = csr_read_data & ~operand;
            default: new_value = operand;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            op                 <= OP_NONE;
            operand            <= '0;
            need_write         <= 1'b0;
            o_ready            <= 1'b1;
            o_done             <= 1'b0;
            o_rdata            <= '0;
            o_error            <= 1'b0;
            csr_request_valid  <= 1'b0;
            csr_address        <= '0;
            csr_write          <= 1'b0;
            csr_write_data     <= '0;
            csr_strobe         <= '0;
            csr_response_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op          <= i_op;
                        operand     <= i_operand;
                        need_write  <= req_need_write;
                        csr_address <= i_address;
                        o_ready     <= 1'b0;
                        o_rdata     <= '0;
                        o_error     <= 1'b0;
                        if (i_op == OP_NONE || req_read_only) begin
                            o_error <= 1'b1;
                            o_done  <= 1'b1;
                            state   <= DONE;
                        end else if (req_need_read) begin
                            csr_request_valid <= 1'b1;
                            csr_write         <= 1'b0;
                            csr_strobe        <= '0;
                            state             <= RD_REQ;
                        end else begin
                            csr_request_valid <= 1'b1;
                            csr_write         <= 1'b1;
                            csr_write_data    <= i_operand;
                            csr_strobe        <= '1;
                            state             <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (csr_request_ready) begin
                        csr_request_valid  <= 1'b0;
                        csr_response_ready <= 1'b1;
                        state              <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (csr_response_valid) begin
                        o_rdata <= csr_read_data;
                        if (csr_error) begin
                            csr_response_ready <= 1'b0;
                            o_error            <= 1'b1;
                            o_done             <= 1'b1;
                            state              <= DONE;
                        end else if (need_write) begin
                            csr_response_ready <= 1'b0;
                            csr_request_valid  <= 1'b1;
                            csr_write          <= 1'b1;
                            csr_write_data     <= new_value;
                            csr_strobe         <= '1;
                            state              <= WR_REQ;
                        end else begin
                            csr_response_ready <= 1'b0;
                            o_done             <= 1'b1;
                            state              <= DONE;
                        end
                    end
                end
                WR_REQ: begin
                    if (csr_request_ready) begin
                        csr_request_valid  <= 1'b0;
                        csr_response_ready <= 1'b1;
                        state              <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (csr_response_valid) begin
                        csr_response_ready <= 1'b0;
                        o_error            <= csr_error;
                        o_done             <= 1'b1;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rice_core_csr_access.sv
// ============================================================================
// tb_rice_core_csr_access : directed bench with a transaction-level CSR model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rice_core_csr_access;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [11:0] i_address;
    logic [31:0] i_operand;
    logic        i_rd_zero;
    logic        i_rs1_zero;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_error;
    logic        csr_request_valid;
    logic        csr_request_ready;
    logic [11:0] csr_address;
    logic        csr_write;
    logic [31:0] csr_write_data;
    logic [3:0]  csr_strobe;
    logic        csr_response_valid;
    logic        csr_response_ready;
    logic [31:0] csr_read_data;
    logic        csr_error;

    rice_core_csr_access #(.XLEN(32)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_op               (i_op),
        .i_address          (i_address),
        .i_operand          (i_operand),
        .i_rd_zero          (i_rd_zero),
        .i_rs1_zero         (i_rs1_zero),
        .o_done             (o_done),
        .o_rdata            (o_rdata),
        .o_error            (o_error),
        .csr_request_valid  (csr_request_valid),
        .csr_request_ready  (csr_request_ready),
        .csr_address        (csr_address),
        .csr_write          (csr_write),
        .csr_write_data     (csr_write_data),
        .csr_strobe         (csr_strobe),
        .csr_response_valid (csr_response_valid),
        .csr_response_ready (csr_response_ready),
        .csr_read_data      (csr_read_data),
        .csr_error          (csr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- CSR slave (environment) ----------------
    logic [31:0] mem [0:4095];
    int          cfg_stalls = 0;
    logic        err_en     = 1'b0;
    logic [11:0] err_addr   = '0;
    int          stall_cnt;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rsp_e;

    function automatic logic [31:0] init_val(input int a);
        if (a == 12'h340) return 32'h12345678;
        if (a == 12'h300) return 32'h00001800;
        return 32'hC5A00000 | 32'(a);
    endfunction

    initial for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);

    assign csr_request_ready  = !rsp_v && (stall_cnt >= cfg_stalls);
    assign csr_response_valid = rsp_v;
    assign csr_read_data      = rsp_d;
    assign csr_error          = rsp_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v     <= 1'b0;
            rsp_d     <= '0;
            rsp_e     <= 1'b0;
            stall_cnt <= 0;
        end else begin
            if (csr_request_valid && csr_request_ready) begin
                rsp_v     <= 1'b1;
                rsp_d     <= mem[csr_address];
                rsp_e     <= err_en && !csr_write && (csr_address == err_addr);
                stall_cnt <= 0;
                if (csr_write) mem[csr_address] <= csr_write_data;
            end else if (csr_request_valid) begin
                stall_cnt <= stall_cnt + 1;
            end
            if (rsp_v && csr_response_ready) rsp_v <= 1'b0;
        end
    end

    // ---------------- model state ----------------
    logic [31:0] model_mem [0:4095];
    logic [48:0] exp_q [$];
    logic [48:0] obs_q [$];
    int          mode = 2;      // 0 idle, 1 transaction in flight, 2 unchecked
    int          cyc;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] last_rdata;
    logic [31:0] last_wdata;
    logic [48:0] held_fields;
    logic        stall_seen = 1'b0;

    function automatic logic [48:0] rec(input logic w, input logic [11:0] a,
                                        input logic [31:0] d, input logic [3:0] s);
        return w ? {1'b1, a, d, s} : {1'b0, a, 36'd0};
    endfunction

    // Single compare process: bus monitor, stall stability and output checks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && csr_request_valid && csr_request_ready) begin
                obs_q.push_back(rec(csr_write, csr_address, csr_write_data, csr_strobe));
                if (csr_write) last_wdata = csr_write_data;
            end
            if (rst_n && csr_request_valid && !csr_request_ready) begin
                if (stall_seen)
                    chk("stall_hold", 128'({csr_address, csr_write, csr_write_data, csr_strobe}),
                        128'(held_fields));
                held_fields = {csr_address, csr_write, csr_write_data, csr_strobe};
                stall_seen  = 1'b1;
            end else begin
                stall_seen = 1'b0;
            end
            if (mode == 0) begin
                chk("idle_outputs", 128'({o_ready, o_done, csr_request_valid}), 128'(3'b100));
            end else if (mode == 1) begin
                cyc++;
                if (cyc < exp_lat) begin
                    chk("done_early", 128'(o_done), 128'(0));
                end else begin
                    chk("done_pulse", 128'(o_done), 128'(1));
                    chk("rdata", 128'(o_rdata), 128'(exp_rdata));
                    chk("error", 128'(o_error), 128'(exp_err));
                    chk("bus_op_count", 128'(obs_q.size()), 128'(exp_q.size()));
                    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                        chk("bus_op", 128'(obs_q[i]), 128'(exp_q[i]));
                    last_rdata = o_rdata;
                    mode = 0;
                end
            end
        end
    end

    task automatic check_reset_vals(input string name);
        chk(name, 128'({o_ready, o_done, o_rdata, o_error, csr_request_valid, csr_write,
                        csr_write_data, csr_strobe, csr_address, csr_response_ready}),
            128'({1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 12'd0, 1'b0}));
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] opd,
                         input logic rdz, input logic rs1z);
        i_valid = 1'b1; i_op = op; i_address = a; i_operand = opd;
        i_rd_zero = rdz; i_rs1_zero = rs1z;
    endtask

    task automatic scramble();
        i_valid    = 1'b0;
        i_op       = 2'($urandom);
        i_address  = 12'($urandom);
        i_operand  = $urandom;
        i_rd_zero  = 1'($urandom);
        i_rs1_zero = 1'($urandom);
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [11:0] a, input logic [31:0] opd,
                          input logic rdz, input logic rs1z, input int stalls, input logic rderr);
        logic        nr;
        logic        nw;
        logic [31:0] old;
        logic [31:0] nv;
        int          nops;
        int          k;
        nr = !(op == 2'b01 && rdz);
        nw = (op == 2'b01) || !rs1z;
        exp_q.delete();
        obs_q.delete();
        nops = 0;
        if (op == 2'b00 || (nw && a[11:10] == 2'b11)) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
        end else begin
            old       = nr ? model_mem[a] : 32'd0;
            exp_rdata = old;
            exp_err   = 1'b0;
            if (nr) begin
                exp_q.push_back(rec(1'b0, a, 32'd0, 4'd0));
                nops++;
            end
            if (nr && rderr) begin
                exp_err = 1'b1;
            end else if (nw) begin
                if (op == 2'b01)      nv = opd;
                else if (op == 2'b10) nv = old | opd;
                else                  nv = old & ~opd;
                exp_q.push_back(rec(1'b1, a, nv, 4'hF));
                model_mem[a] = nv;
                nops++;
            end
        end
        exp_lat    = 1 + nops * (2 + stalls);
        cfg_stalls = stalls;
        err_en     = rderr;
        err_addr   = a;
        @(negedge clk);
        drive(op, a, opd, rdz, rs1z);
        @(posedge clk);
        #1;
        scramble();
        cyc  = 0;
        mode = 1;
        k    = 0;
        while (mode == 1 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (mode == 1) begin
            checks++;
            errors++;
            $display("FAIL timeout: no o_done within %0d cycles, expected at cycle %0d", k, exp_lat);
            mode = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);
        rst_n = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check_reset_vals("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset_release");
        mode = 0;

        // RMW: CSRRW mscratch
        do_txn(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 0, 1'b0);
        chk("lit_rw_latency", 128'(cyc), 128'(5));
        chk("lit_rw_rdata", 128'(last_rdata), 128'(32'h12345678));
        chk("lit_rw_wdata", 128'(last_wdata), 128'(32'hDEADBEEF));

        // CSRRS then CSRRC with the same mask
        do_txn(2'b10, 12'h300, 32'h8, 1'b0, 1'b0, 0, 1'b0);
        chk("lit_rs_wdata", 128'(last_wdata), 128'(32'h1808));
        chk("lit_rs_rdata", 128'(last_rdata), 128'(32'h1800));
        do_txn(2'b11, 12'h300, 32'h8, 1'b0, 1'b0, 0, 1'b0);
        chk("lit_rc_wdata", 128'(last_wdata), 128'(32'h1800));
        chk("lit_rc_rdata", 128'(last_rdata), 128'(32'h1808));

        // Read-only space: read allowed, write faults locally
        do_txn(2'b10, 12'hF14, 32'h0, 1'b0, 1'b1, 0, 1'b0);
        chk("lit_ro_read_latency", 128'(cyc), 128'(3));
        do_txn(2'b01, 12'hF14, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        chk("lit_ro_write_latency", 128'(cyc), 128'(1));

        // Write only (rd = x0)
        do_txn(2'b01, 12'h340, 32'hCAFEF00D, 1'b1, 1'b0, 0, 1'b0);
        chk("lit_wo_latency", 128'(cyc), 128'(3));
        chk("lit_wo_rdata", 128'(last_rdata), 128'(0));

        // Invalid op
        do_txn(2'b00, 12'h340, 32'h5, 1'b0, 1'b0, 0, 1'b0);

        // Read error with 3 ready stalls
        do_txn(2'b01, 12'h7C0, 32'h77, 1'b0, 1'b0, 3, 1'b0 | 1'b1);
        chk("lit_rderr_latency", 128'(cyc), 128'(6));

        // Stalled RMW write-back
        do_txn(2'b11, 12'h300, 32'h800, 1'b0, 1'b0, 2, 1'b0);
        chk("lit_stall_rc_wdata", 128'(last_wdata), 128'(32'h1000));

        // Reset asserted while in WR_RSP
        cfg_stalls = 0;
        err_en     = 1'b0;
        mode       = 2;
        @(negedge clk);
        drive(2'b01, 12'h341, 32'h000055AA, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        scramble();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("rst_test_no_done", 128'(o_done), 128'(0));
        end
        chk("rst_test_in_wr_rsp", 128'({csr_write, csr_response_ready, csr_request_valid}),
            128'(3'b110));
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_txn_reset");
        @(negedge clk);
        chk("rst_test_no_done_after", 128'(o_done), 128'(0));
        rst_n = 1'b1;
        model_mem[12'h341] = 32'h000055AA;
        obs_q.delete();
        @(negedge clk);
        check_reset_vals("after_mid_reset_release");
        mode = 0;

        do_txn(2'b10, 12'h341, 32'h0, 1'b0, 1'b1, 0, 1'b0);
        chk("lit_post_reset_rdata", 128'(last_rdata), 128'(32'h000055AA));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
